prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader sitting directly upstream of the top-level memory muxes. It consumes a byte stream from the UART receiver and assembles little-endian 32-bit words. Each word is written to data memory. Each group of four words is also written to instruction memory as one 128-bit fetch line. While `done` is low, the top level holds the pipeline in reset and routes `addr`/`data`/`we_32`/`we_128` to the memories; `done` rising releases the core.

## Interface
Parameters:
- `MAX_WORDS`, 2048: words actually written (8 KiB, matches 9-bit imem line index); excess words are consumed and discarded.
- `ADDR_LEN`, 32: address width (shared constant).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid; no backpressure, at most one byte per cycle.
- `addr` out `ADDR_LEN`: byte address of the word just completed (4·k).
- `data` out 128: assembly line; newest word at [127:96], imem line layout slot0 at [31:0].
- `we_32` out 1: one-cycle dmem write strobe (data[127:96] → addr).
- `we_128` out 1: one-cycle imem write strobe (data → line addr[12:4]).
- `done` out 1: sticky load-complete flag.
- `busy` out 1: high in S_DATA/S_FLUSH.

## Operation
- Reset values: `addr`=0, `data`=0, `we_32`=0, `we_128`=0, `done`=0, `busy`=0, state S_HDR, byte/word counters 0.
- S_HDR: collect 4 bytes, little-endian, into word count N (byte0 = N[7:0]). On 4th byte: N=0 → S_DONE; else → S_DATA.
- S_DATA: bytes shift into a 32-bit word register, byte0 at [7:0]. On 4th byte of word k:
  - `data` <= {word, data[127:32]}, `addr` <= 4·k, `we_32` pulses.
  - If k mod 4 = 3, `we_128` pulses in the same cycle.
  - k increments.
- Word k ≥ MAX_WORDS: counted, no strobes, `data`/`addr` unchanged.
- Last word (k = N−1):
  - If N mod 4 = 0 or N > MAX_WORDS → S_DONE.
  - Else → S_FLUSH.
- S_FLUSH, one cycle: `data` <= data >> (32·(4 − N mod 4)), zero-filled. `we_128` pulses; `addr` holds the last word address. → S_DONE.
- S_DONE: `done`=1. All `rx_valid` ignored until reset.
- `rx_valid` while in S_FLUSH: byte dropped (protocol violation, no error flag).
- Counters are 32-bit. N up to 2^32−1 is accepted; no wrap within a load.

## Timing
- Byte completing a word accepted at edge t; `we_32`/`we_128`/`addr`/`data` valid in cycle t+1, for one cycle.
- Flush strobe in cycle t+2 after the last byte at t. `done` rises at t+3.
- Without flush, `done` rises at t+2, one cycle after the final write strobe, so the final write always precedes core release.
- N=0: `done` rises cycle after 4th header byte.
- Back-to-back bytes every cycle are supported; gaps of any length are allowed between bytes.
- Reset asserted mid-load aborts immediately: outputs go to reset values asynchronously, and the partial word is discarded. Load restarts at S_HDR after deassertion.

## Structure
- Shared package: `ADDR_LEN`, `DATA_LEN`, `INSN_LEN`, state enum {S_HDR, S_DATA, S_FLUSH, S_DONE}, `LOADER_MAX_WORDS` default.
- One sub-module: `ploader_byte_asm`, the 4-byte little-endian word assembler with a `word_valid` strobe. It is used for both the header and payload.
- All outputs registered; no combinational path from `rx_*` to outputs.

## Test plan
- Header 00 00 00 00 → no strobes; `done`=1 one cycle after 4th byte.
- N=4, words 0x00000013, 0x00100093, 0x00200113, 0x00308193 → four `we_32` at addr 0,4,8,C; `we_128` with word 4, `data`=0x00308193_00200113_00100093_00000013, addr=0xC; `done` next cycle.
- N=6 → six `we_32`, `we_128` at addr 0xC. Flush `we_128` with addr=0x14, data={64'h0, w5, w4}; `done` after.
- Bytes with random 0–5 cycle gaps versus back-to-back → identical strobe sequence and data; exactly one cycle per strobe.
- Reset asserted after 2 bytes of word 2 (N=4) → outputs zero at once; a fresh N=1 load writes addr 0, flush line {96'h0, w0}.
- MAX_WORDS=4, N=5 → strobes for words 0–3 only; 5th word consumed silently; `done`=1; extra bytes after `done` ignored.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the boot-time program loader.
package prog_loader_pkg;

    localparam int ADDR_LEN         = 32;
    localparam int DATA_LEN         = 32;
    localparam int INSN_LEN         = 128;
    localparam int LOADER_MAX_WORDS = 2048;

    typedef enum logic [1:0] {
        S_HDR,
        S_DATA,
        S_FLUSH,
        S_DONE
    } loader_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and memory write bus of the program loader.
// slave: the loader itself; master: the UART/memory side.
interface prog_loader_if #(
    parameter int ADDR_LEN = prog_loader_pkg::ADDR_LEN
);
    import prog_loader_pkg::*;

    logic [7:0]          rx_data;
    logic                rx_valid;
    logic [ADDR_LEN-1:0] addr;
    logic [INSN_LEN-1:0] data;
    logic                we_32;
    logic                we_128;
    logic                done;
    logic                busy;

    modport master (
        output rx_data, rx_valid,
        input  addr, data, we_32, we_128, done, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output addr, data, we_32, we_128, done, busy
    );

endinterface

// File: rtl/ploader_byte_asm.sv
// Little-endian 4-byte word assembler. word/word_valid are combinational
// from the byte completing the word so the consumer can register its
// outputs on that same edge.
module ploader_byte_asm
    import prog_loader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic [DATA_LEN-1:0] word,
    output logic                word_valid
);

    logic [1:0]          cnt;
    logic [DATA_LEN-9:0] shreg;

    // Shift bytes in from the top so byte0 ends up in the low lane.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (byte_valid) begin
            cnt   <= cnt + 2'd1;
            shreg <= {byte_in, shreg[DATA_LEN-9:8]};
        end
    end

    assign word       = {byte_in, shreg};
    assign word_valid = byte_valid && (cnt == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: header word N, then N little-endian words.
// Each word goes to dmem; each group of four forms one imem fetch line.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int MAX_WORDS = LOADER_MAX_WORDS,
    parameter int ADDR_LEN  = prog_loader_pkg::ADDR_LEN
) (
    input  logic           clk,
    input  logic           reset,
    prog_loader_if.slave   bus
);

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    loader_state_t       state;
    logic [31:0]         n_words;
    logic [31:0]         k;
    logic [DATA_LEN-1:0] word;
    logic                word_valid;
    logic                asm_valid;

    // Bytes arriving during flush or after completion never reach the assembler.
    assign asm_valid = bus.rx_valid && (state == S_HDR || state == S_DATA);

    ploader_byte_asm u_asm (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (bus.rx_data),
        .byte_valid (asm_valid),
        .word       (word),
        .word_valid (word_valid)
    );

    // Load sequencer with registered memory strobes, line assembly and status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_HDR;
            n_words    <= '0;
            k          <= '0;
            bus.addr   <= '0;
            bus.data   <= '0;
            bus.we_32  <= 1'b0;
            bus.we_128 <= 1'b0;
            bus.done   <= 1'b0;
            bus.busy   <= 1'b0;
        end else begin
            bus.we_32  <= 1'b0;
            bus.we_128 <= 1'b0;
            case (state)
                S_HDR: begin
                    if (word_valid) begin
                        n_words <= word;
                        k       <= '0;
                        if (word == '0) begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state    <= S_DATA;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (word_valid) begin
                        if (k < MAX_W) begin
                            bus.data   <= {word, bus.data[INSN_LEN-1:DATA_LEN]};
                            bus.addr   <= ADDR_LEN'({k, 2'b00});
                            bus.we_32  <= 1'b1;
                            bus.we_128 <= (k[1:0] == 2'b11);
                        end
                        k <= k + 32'd1;
                        if (k == n_words - 32'd1) begin
                            if (n_words[1:0] == 2'b00 || n_words > MAX_W) begin
                                state    <= S_DONE;
                                bus.busy <= 1'b0;
                            end else begin
                                state <= S_FLUSH;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    // Realign a partial line so its oldest word lands in slot 0.
                    case (n_words[1:0])
                        2'd1:    bus.data <= bus.data >> 96;
                        2'd2:    bus.data <= bus.data >> 64;
                        2'd3:    bus.data <= bus.data >> 32;
                        default: bus.data <= bus.data;
                    endcase
                    bus.we_128 <= 1'b1;
                    state      <= S_DONE;
                    bus.busy   <= 1'b0;
                end
                S_DONE: begin
                    bus.done <= 1'b1;
                end
                default: begin
                    state <= S_HDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: expected write strobes are derived
// from the load rules (word list, line grouping, flush) and compared to
// strobes captured on every cycle.
module tb_prog_loader;
    import prog_loader_pkg::*;

    typedef struct {
        logic         we32;
        logic         we128;
        logic [31:0]  addr;
        logic [127:0] data;
        int           cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_bad = 0;

    prog_loader_if bus_a ();
    prog_loader_if bus_b ();

    prog_loader dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (bus_a.slave)
    );

    prog_loader #(.MAX_WORDS(4)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (bus_b.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t         got_a[$];
    ev_t         got_b[$];
    int          done_a = -1;
    int          done_b = -1;
    logic [31:0] words_q[$];
    logic [7:0]  bytes_q[$];
    int          acc_q[$];
    ev_t         exp_q[$];
    int          exp_done;

    // Capture every strobe cycle and the first cycle done is seen.
    always @(negedge clk) begin
        ev_t e;
        if (!reset_a) begin
            if (bus_a.we_32 || bus_a.we_128) begin
                e.we32 = bus_a.we_32; e.we128 = bus_a.we_128;
                e.addr = bus_a.addr;  e.data = bus_a.data; e.cyc = cyc;
                got_a.push_back(e);
            end
            if (bus_a.done && done_a < 0) done_a = cyc;
        end
        if (!reset_b) begin
            if (bus_b.we_32 || bus_b.we_128) begin
                e.we32 = bus_b.we_32; e.we128 = bus_b.we_128;
                e.addr = bus_b.addr;  e.data = bus_b.data; e.cyc = cyc;
                got_b.push_back(e);
            end
            if (bus_b.done && done_b < 0) done_b = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_checks, n_bad);
        $fatal(1, "watchdog");
    end

    task automatic set_rx(input int inst, input logic v, input logic [7:0] d);
        if (inst == 0) begin bus_a.rx_valid = v; bus_a.rx_data = d; end
        else begin bus_b.rx_valid = v; bus_b.rx_data = d; end
    endtask

    task automatic reset_dut(input int inst);
        if (inst == 0) reset_a = 1'b1; else reset_b = 1'b1;
        got_a.delete(); got_b.delete(); done_a = -1; done_b = -1;
        repeat (2) @(negedge clk);
        if (inst == 0) reset_a = 1'b0; else reset_b = 1'b0;
    endtask

    task automatic build_stream(input int n);
        logic [31:0] nv;
        nv = n;
        bytes_q.delete();
        for (int b = 0; b < 4; b++) bytes_q.push_back(nv[8*b +: 8]);
        foreach (words_q[i]) begin
            logic [31:0] w;
            w = words_q[i];
            for (int b = 0; b < 4; b++) bytes_q.push_back(w[8*b +: 8]);
        end
    endtask

    // Drive the first nbytes of bytes_q; acc_q records the cycle each was accepted.
    task automatic drive(input int inst, input int gap_max, input int nbytes);
        acc_q.delete();
        for (int i = 0; i < nbytes; i++) begin
            int gap;
            gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            set_rx(inst, 1'b0, 8'h00);
            repeat (gap) @(negedge clk);
            set_rx(inst, 1'b1, bytes_q[i]);
            @(negedge clk);
            acc_q.push_back(cyc);
        end
        set_rx(inst, 1'b0, 8'h00);
    endtask

    // Expected strobes: word k writes addr 4k with the last four words as the line;
    // a partial final line is flushed with its words packed from slot 0.
    task automatic build_model(input int n, input int maxw);
        int  nw;
        bit  flush;
        exp_q.delete();
        nw = (n < maxw) ? n : maxw;
        for (int k = 0; k < nw; k++) begin
            ev_t e;
            e.we32 = 1'b1; e.we128 = (k % 4 == 3); e.addr = 32'(4 * k); e.data = '0;
            for (int s = 0; s < 4; s++)
                if (k - 3 + s >= 0) e.data[32*s +: 32] = words_q[k - 3 + s];
            e.cyc = acc_q[4 + 4 * k + 3];
            exp_q.push_back(e);
        end
        if (n == 0) begin
            exp_done = acc_q[3];
        end else begin
            flush = (n % 4 != 0) && (n <= maxw);
            if (flush) begin
                ev_t e;
                int  r;
                r = n % 4;
                e.we32 = 1'b0; e.we128 = 1'b1; e.addr = 32'(4 * (n - 1)); e.data = '0;
                for (int s = 0; s < r; s++) e.data[32*s +: 32] = words_q[n - r + s];
                e.cyc = acc_q[4 * n + 3] + 1;
                exp_q.push_back(e);
            end
            exp_done = acc_q[4 * n + 3] + (flush ? 2 : 1);
        end
    endtask

    task automatic test_reset();
        reset_a = 1'b1; reset_b = 1'b1;
        set_rx(0, 1'b0, 8'h00); set_rx(1, 1'b0, 8'h00);
        @(negedge clk);
        n_checks++;
        if (bus_a.addr !== '0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", bus_a.addr); end
        n_checks++;
        if (bus_a.data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", bus_a.data); end
        n_checks++;
        if ({bus_a.we_32, bus_a.we_128, bus_a.done, bus_a.busy} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: got we32/we128/done/busy=%b want 0000",
                              {bus_a.we_32, bus_a.we_128, bus_a.done, bus_a.busy});
        end
        n_checks++;
        if ({bus_b.addr, bus_b.data, bus_b.we_32, bus_b.we_128, bus_b.done, bus_b.busy} !== '0) begin
            n_bad++; $display("FAIL reset_b: got addr=%h data=%h done=%b busy=%b want all 0",
                              bus_b.addr, bus_b.data, bus_b.done, bus_b.busy);
        end
        reset_a = 1'b0; reset_b = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus_a.done, bus_a.busy, bus_a.we_32} !== 3'b000) begin
            n_bad++; $display("FAIL idle_after_reset: got done/busy/we32=%b want 000",
                              {bus_a.done, bus_a.busy, bus_a.we_32});
        end
    endtask

    task automatic test_empty();
        reset_dut(0);
        words_q.delete();
        build_stream(0);
        drive(0, 0, bytes_q.size());
        repeat (6) @(negedge clk);
        build_model(0, LOADER_MAX_WORDS);
        n_checks++;
        if (got_a.size() != 0) begin n_bad++; $display("FAIL empty_strobes: got %0d want 0", got_a.size()); end
        n_checks++;
        if (done_a !== exp_done) begin n_bad++; $display("FAIL empty_done_cycle: got %0d want %0d", done_a, exp_done); end
        n_checks++;
        if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL empty_busy: got %b want 0", bus_a.busy); end
    endtask

    // N=4 fixed program (full line, no flush) and N=6 random (flush of two words).
    task automatic test_payload();
        int nlist[2] = '{4, 6};
        for (int c = 0; c < 2; c++) begin
            int n;
            n = nlist[c];
            reset_dut(0);
            words_q.delete();
            if (n == 4) begin
                words_q.push_back(32'h00000013); words_q.push_back(32'h00100093);
                words_q.push_back(32'h00200113); words_q.push_back(32'h00308193);
            end else begin
                for (int i = 0; i < n; i++) words_q.push_back($urandom);
            end
            build_stream(n);
            drive(0, 0, bytes_q.size());
            repeat (6) @(negedge clk);
            build_model(n, LOADER_MAX_WORDS);
            n_checks++;
            if (got_a.size() != exp_q.size()) begin
                n_bad++; $display("FAIL payload_n%0d_count: got %0d want %0d", n, got_a.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
                n_checks++;
                if (got_a[i].we32 !== exp_q[i].we32 || got_a[i].we128 !== exp_q[i].we128 ||
                    got_a[i].addr !== exp_q[i].addr || got_a[i].data !== exp_q[i].data ||
                    got_a[i].cyc != exp_q[i].cyc) begin
                    n_bad++;
                    $display("FAIL payload_n%0d_ev%0d: got we32=%b we128=%b addr=%h data=%h cyc=%0d want we32=%b we128=%b addr=%h data=%h cyc=%0d",
                             n, i, got_a[i].we32, got_a[i].we128, got_a[i].addr, got_a[i].data, got_a[i].cyc,
                             exp_q[i].we32, exp_q[i].we128, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
                end
            end
            if (n == 4 && got_a.size() >= 4) begin
                n_checks++;
                if (got_a[3].data !== 128'h00308193_00200113_00100093_00000013 || got_a[3].we128 !== 1'b1) begin
                    n_bad++; $display("FAIL payload_line: got we128=%b data=%h want 1 00308193002001130010009300000013",
                                      got_a[3].we128, got_a[3].data);
                end
            end
            n_checks++;
            if (done_a !== exp_done) begin n_bad++; $display("FAIL payload_n%0d_done_cycle: got %0d want %0d", n, done_a, exp_done); end
            n_checks++;
            if (bus_a.busy !== 1'b0) begin n_bad++; $display("FAIL payload_n%0d_busy_end: got %b want 0", n, bus_a.busy); end
        end
    endtask

    // Same random program back-to-back and with random gaps: strobes must follow the model either way.
    task automatic test_gaps();
        for (int t = 0; t < 5; t++) begin
            int n;
            n = int'($urandom_range(11, 1));
            words_q.delete();
            for (int i = 0; i < n; i++) words_q.push_back($urandom);
            for (int m = 0; m < 2; m++) begin
                int gmax;
                gmax = (m == 0) ? 0 : 5;
                reset_dut(0);
                build_stream(n);
                drive(0, gmax, bytes_q.size());
                repeat (6) @(negedge clk);
                build_model(n, LOADER_MAX_WORDS);
                n_checks++;
                if (got_a.size() != exp_q.size()) begin
                    n_bad++; $display("FAIL gaps_t%0d_g%0d_count: got %0d want %0d", t, gmax, got_a.size(), exp_q.size());
                end
                for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
                    n_checks++;
                    if (got_a[i].we32 !== exp_q[i].we32 || got_a[i].we128 !== exp_q[i].we128 ||
                        got_a[i].addr !== exp_q[i].addr || got_a[i].data !== exp_q[i].data ||
                        got_a[i].cyc != exp_q[i].cyc) begin
                        n_bad++;
                        $display("FAIL gaps_t%0d_g%0d_ev%0d: got we32=%b we128=%b addr=%h data=%h cyc=%0d want we32=%b we128=%b addr=%h data=%h cyc=%0d",
                                 t, gmax, i, got_a[i].we32, got_a[i].we128, got_a[i].addr, got_a[i].data, got_a[i].cyc,
                                 exp_q[i].we32, exp_q[i].we128, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
                    end
                end
                n_checks++;
                if (done_a !== exp_done) begin
                    n_bad++; $display("FAIL gaps_t%0d_g%0d_done_cycle: got %0d want %0d", t, gmax, done_a, exp_done);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] w0, w1;
        reset_dut(0);
        words_q.delete();
        for (int i = 0; i < 4; i++) words_q.push_back($urandom | 32'h1);
        w0 = words_q[0]; w1 = words_q[1];
        build_stream(4);
        drive(0, 0, 4 + 8 + 2);
        n_checks++;
        if (bus_a.busy !== 1'b1 || bus_a.data !== {w1, w0, 64'h0}) begin
            n_bad++; $display("FAIL abort_pre: got busy=%b data=%h want 1 %h", bus_a.busy, bus_a.data, {w1, w0, 64'h0});
        end
        #2 reset_a = 1'b1;
        #1;
        n_checks++;
        if ({bus_a.addr, bus_a.data, bus_a.we_32, bus_a.we_128, bus_a.done, bus_a.busy} !== '0) begin
            n_bad++; $display("FAIL abort_async_clear: got addr=%h data=%h busy=%b want all 0",
                              bus_a.addr, bus_a.data, bus_a.busy);
        end
        @(negedge clk);
        reset_dut(0);
        words_q.delete();
        words_q.push_back($urandom);
        build_stream(1);
        drive(0, 2, bytes_q.size());
        repeat (6) @(negedge clk);
        build_model(1, LOADER_MAX_WORDS);
        n_checks++;
        if (got_a.size() != exp_q.size()) begin
            n_bad++; $display("FAIL abort_reload_count: got %0d want %0d", got_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            n_checks++;
            if (got_a[i].we32 !== exp_q[i].we32 || got_a[i].we128 !== exp_q[i].we128 ||
                got_a[i].addr !== exp_q[i].addr || got_a[i].data !== exp_q[i].data ||
                got_a[i].cyc != exp_q[i].cyc) begin
                n_bad++;
                $display("FAIL abort_reload_ev%0d: got we32=%b we128=%b addr=%h data=%h cyc=%0d want we32=%b we128=%b addr=%h data=%h cyc=%0d",
                         i, got_a[i].we32, got_a[i].we128, got_a[i].addr, got_a[i].data, got_a[i].cyc,
                         exp_q[i].we32, exp_q[i].we128, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
            end
        end
        n_checks++;
        if (done_a !== exp_done) begin n_bad++; $display("FAIL abort_reload_done: got %0d want %0d", done_a, exp_done); end
    endtask

    // MAX_WORDS=4 instance with N=5: fifth word consumed silently, then trailing bytes ignored.
    task automatic test_max_words();
        int          nev;
        logic [127:0] line;
        reset_dut(1);
        words_q.delete();
        for (int i = 0; i < 5; i++) words_q.push_back($urandom);
        build_stream(5);
        drive(1, 2, bytes_q.size());
        repeat (6) @(negedge clk);
        build_model(5, 4);
        n_checks++;
        if (got_b.size() != exp_q.size()) begin
            n_bad++; $display("FAIL max_count: got %0d want %0d", got_b.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
            n_checks++;
            if (got_b[i].we32 !== exp_q[i].we32 || got_b[i].we128 !== exp_q[i].we128 ||
                got_b[i].addr !== exp_q[i].addr || got_b[i].data !== exp_q[i].data ||
                got_b[i].cyc != exp_q[i].cyc) begin
                n_bad++;
                $display("FAIL max_ev%0d: got we32=%b we128=%b addr=%h data=%h cyc=%0d want we32=%b we128=%b addr=%h data=%h cyc=%0d",
                         i, got_b[i].we32, got_b[i].we128, got_b[i].addr, got_b[i].data, got_b[i].cyc,
                         exp_q[i].we32, exp_q[i].we128, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
            end
        end
        n_checks++;
        if (done_b !== exp_done) begin n_bad++; $display("FAIL max_done_cycle: got %0d want %0d", done_b, exp_done); end
        nev  = got_b.size();
        line = {words_q[3], words_q[2], words_q[1], words_q[0]};
        bytes_q.delete();
        for (int i = 0; i < 8; i++) bytes_q.push_back(8'($urandom));
        drive(1, 1, 8);
        repeat (4) @(negedge clk);
        n_checks++;
        if (got_b.size() != nev) begin n_bad++; $display("FAIL max_after_done_strobes: got %0d want %0d", got_b.size(), nev); end
        n_checks++;
        if (bus_b.done !== 1'b1 || bus_b.data !== line || bus_b.addr !== 32'hC) begin
            n_bad++; $display("FAIL max_after_done_state: got done=%b addr=%h data=%h want 1 0000000c %h",
                              bus_b.done, bus_b.addr, bus_b.data, line);
        end
    endtask

    initial begin
        set_rx(0, 1'b0, 8'h00);
        set_rx(1, 1'b0, 8'h00);
        @(negedge clk);
        test_reset();
        test_empty();
        test_payload();
        test_gaps();
        test_reset_abort();
        test_max_words();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
